seg_scan_encoder: RTL

- Upstream feeder for the 74HC595 serial shift driver on the six-digit seven-segment board.
- Takes a 20-bit binary value plus decimal-point mask and converts it to six BCD digits with an iterative double-dabble engine.
- Time-multiplexes the digits and presents a registered 16-bit {segment, select} word.
- The shift driver reloads this word continuously, so there is no handshake on the output.

---
 rtl/seg_scan_encoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_encoder.sv
// Binary-to-BCD (iterative double-dabble) plus six-digit multiplexed segment scan for a 74HC595 shift driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits; undefined shows all six numerals.
module seg_scan_encoder #(
    parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999,
    parameter logic [19:0] BCD_MAX      = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        seg_en,
    output logic [15:0] data_out,
    output logic        conv_busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [19:0] last_q, last_d;
    logic [19:0] bin_q, bin_d;
    logic [23:0] work_q, work_d;
    logic [4:0]  iter_q, iter_d;
    logic [23:0] disp_q, disp_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] dout_q, dout_d;

    logic [23:0] work_adj;
    logic [43:0] shifted;
    logic [3:0]  cur_digit;
    logic [6:0]  seg_code;
    logic        digit_blank;
    logic [7:0]  seg_byte;

    genvar gi;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    for (gi = 0; gi < 6; gi++) begin : g_adj
        assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ? work_q[4*gi +: 4] + 4'd3
                                                                 : work_q[4*gi +: 4];
    end

    assign shifted = {work_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bin_d   = bin_q;
        work_d  = work_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (data != last_q) begin
                    bin_d   = (data > BCD_MAX) ? BCD_MAX : data;
                    last_d  = data;
                    work_d  = 24'd0;
                    iter_d  = 5'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted[43:20];
                bin_d  = shifted[19:0];
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd19) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d  = work_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q == CNT_SCAN_MAX) begin
            cnt_d = 16'd0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        case (cur_digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only if it and everything above are zero and no dp sits to its left
    logic [5:0] blank_vec;
    assign blank_vec[0] = 1'b0;
    for (gi = 1; gi < 6; gi++) begin : g_blank
        if (gi == 5) begin : g_top
            assign blank_vec[gi] = ~|disp_q[23:20];
        end else begin : g_mid
            assign blank_vec[gi] = ~|disp_q[23:4*gi] & ~|point[5:gi+1];
        end
    end
    assign digit_blank = blank_vec[idx_q];
`else
    assign digit_blank = 1'b0;
`endif

    assign seg_byte = {~point[idx_q], digit_blank ? 7'h7F : seg_code};

    always_comb begin
        dout_d = 16'hFF00;
        if (seg_en) begin
            dout_d = {seg_byte, 2'b00, 6'b000001 << idx_q};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            last_q  <= 20'd0;
            bin_q   <= 20'd0;
            work_q  <= 24'd0;
            iter_q  <= 5'd0;
            disp_q  <= 24'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= 16'd0;
            idx_q  <= 3'd0;
            dout_q <= 16'hFF00;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            dout_q <= dout_d;
        end
    end

    assign data_out  = dout_q;
    assign conv_busy = busy_q;

endmodule
